// File: rtl/writeback_arbiter.sv
// writeback_arbiter
// Collects results from N_UNITS calculation units into small per-unit FIFOs and
// grants at most one per cycle onto the register-file write port. A result for
// x0 is retired (retire_o) without asserting the write enable.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             drop every buffered and same-cycle result
//   unit_v/rd/data    per-unit result offer (rd and data packed, unit 0 in LSBs)
//   unit_ready        per-unit buffer not full (registered)
//   res_v/adr/data    register-file write port (registered)
//   retire_o          one pulse per result leaving the block, x0 included
//
// Build option
//   WB_ARB_ROUND_ROBIN_EN  round-robin grant starting after the last winner;
//                          undefined -> fixed priority, lowest unit index wins.
module writeback_arbiter #(
  parameter int N_UNITS = 3,
  parameter int DEPTH   = 2,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [N_UNITS-1:0]         unit_v,
  input  logic [N_UNITS*5-1:0]       unit_rd,
  input  logic [N_UNITS*DATA_W-1:0]  unit_data,
  output logic [N_UNITS-1:0]         unit_ready,
  output logic                       res_v,
  output logic [4:0]                 res_adr,
  output logic [DATA_W-1:0]          res_data,
  output logic                       retire_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [4:0]        rd_mem   [N_UNITS][DEPTH];
  logic [DATA_W-1:0] data_mem [N_UNITS][DEPTH];
  logic [CNT_W-1:0]  count_q  [N_UNITS];
  logic [CNT_W-1:0]  count_d  [N_UNITS];
  logic [PTR_W-1:0]  wptr_q   [N_UNITS];
  logic [PTR_W-1:0]  rptr_q   [N_UNITS];
  logic [N_UNITS-1:0] ready_q;
  logic [N_UNITS-1:0] push;
  logic [N_UNITS-1:0] pop;

  logic              res_v_q, retire_q;
  logic [4:0]        res_adr_q;
  logic [DATA_W-1:0] res_data_q;

  logic              gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic [4:0]        head_rd;
  logic [DATA_W-1:0] head_data;

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]  ptr_q;
`endif

  always_comb begin
    gnt     = 1'b0;
    gnt_idx = '0;
    // Lowest non-empty index overall.
    for (int i = N_UNITS - 1; i >= 0; i--) begin
      if (count_q[i] != '0) begin
        gnt     = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
`ifdef WB_ARB_ROUND_ROBIN_EN
    // Lowest non-empty index at or above the pointer overrides the wrap-around pick.
    for (int i = N_UNITS - 1; i >= 0; i--) begin
      if (count_q[i] != '0 && IDX_W'(i) >= ptr_q) begin
        gnt_idx = IDX_W'(i);
      end
    end
`endif
    if (flush) gnt = 1'b0;

    pop       = '0;
    head_rd   = '0;
    head_data = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (gnt && gnt_idx == IDX_W'(i)) begin
        pop[i]    = 1'b1;
        head_rd   = rd_mem[i][rptr_q[i]];
        head_data = data_mem[i][rptr_q[i]];
      end
    end

    for (int i = 0; i < N_UNITS; i++) begin
      push[i]    = unit_v[i] & ready_q[i] & ~flush;
      count_d[i] = flush ? '0
                 : count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_UNITS; i++) begin
        count_q[i] <= '0;
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
      end
      ready_q    <= '0;
      res_v_q    <= 1'b0;
      retire_q   <= 1'b0;
      res_adr_q  <= '0;
      res_data_q <= '0;
`ifdef WB_ARB_ROUND_ROBIN_EN
      ptr_q      <= '0;
`endif
    end else begin
      for (int i = 0; i < N_UNITS; i++) begin
        count_q[i] <= count_d[i];
        ready_q[i] <= (count_d[i] < FULL);
        if (flush) begin
          wptr_q[i] <= '0;
          rptr_q[i] <= '0;
        end else begin
          if (push[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
          if (pop[i])  rptr_q[i] <= rptr_q[i] + 1'b1;
        end
      end
      retire_q <= gnt;
      res_v_q  <= gnt && (head_rd != 5'd0);
      if (gnt && head_rd != 5'd0) begin
        res_adr_q  <= head_rd;
        res_data_q <= head_data;
      end
`ifdef WB_ARB_ROUND_ROBIN_EN
      if (gnt) ptr_q <= (gnt_idx == IDX_W'(N_UNITS - 1)) ? '0 : gnt_idx + 1'b1;
`endif
    end
  end

  // Storage needs no reset: counts gate every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_UNITS; i++) begin
      if (push[i]) begin
        rd_mem[i][wptr_q[i]]   <= unit_rd[i*5 +: 5];
        data_mem[i][wptr_q[i]] <= unit_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign unit_ready = ready_q;
  assign res_v      = res_v_q;
  assign res_adr    = res_adr_q;
  assign res_data   = res_data_q;
  assign retire_o   = retire_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;
  localparam int N = 3;
  localparam int D = 2;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic [N-1:0]   unit_v = '0;
  logic [N*5-1:0] unit_rd = '0;
  logic [N*W-1:0] unit_data = '0;
  logic [N-1:0]   unit_ready;
  logic           res_v;
  logic [4:0]     res_adr;
  logic [W-1:0]   res_data;
  logic           retire_o;

  always #5 clk = ~clk;

  writeback_arbiter #(.N_UNITS(N), .DEPTH(D), .DATA_W(W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .unit_v(unit_v), .unit_rd(unit_rd), .unit_data(unit_data),
    .unit_ready(unit_ready),
    .res_v(res_v), .res_adr(res_adr), .res_data(res_data),
    .retire_o(retire_o)
  );

  typedef struct packed {
    logic [4:0]   rd;
    logic [W-1:0] data;
  } ent_t;

  // Reference model: per-unit queues of pending results.
  ent_t         mq [N][$];
  int           m_ptr = 0;
  logic         e_res_v = 1'b0, e_retire = 1'b0;
  logic [4:0]   e_adr = '0;
  logic [W-1:0] e_data = '0;
  logic [N-1:0] e_ready = '0;
  bit           adr_known = 1'b0;
  logic [N-1:0] acc = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int x0_writes = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    int   win;
    ent_t e;
    acc = '0;
    if (rst) begin
      for (int u = 0; u < N; u++) mq[u].delete();
      m_ptr = 0; e_res_v = 0; e_retire = 0; e_adr = '0; e_data = '0;
      e_ready = '0; adr_known = 1;
    end else if (flush) begin
      for (int u = 0; u < N; u++) mq[u].delete();
      e_res_v = 0; e_retire = 0; e_ready = '1;
    end else begin
      win = -1;
      for (int k = 0; k < N; k++) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
        int u = (m_ptr + k) % N;
`else
        int u = k;
`endif
        if (win < 0 && mq[u].size() > 0) win = u;
      end
      if (win >= 0) begin
        e = mq[win].pop_front();
        e_retire = 1;
        e_res_v  = (e.rd != 0);
        if (e.rd != 0) begin
          e_adr = e.rd; e_data = e.data; adr_known = 1;
        end else begin
          adr_known = 0;
        end
        m_ptr = (win + 1) % N;
      end else begin
        e_res_v = 0; e_retire = 0;
      end
      for (int u = 0; u < N; u++) begin
        if (unit_v[u] && e_ready[u]) begin
          e.rd = unit_rd[u*5 +: 5]; e.data = unit_data[u*W +: W];
          mq[u].push_back(e);
          acc[u] = 1'b1;
        end
      end
      for (int u = 0; u < N; u++) e_ready[u] = (mq[u].size() < D);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (res_v === 1'b1 && res_adr == 5'd0) x0_writes++;
    chk("res_v", {63'd0, res_v}, {63'd0, e_res_v});
    chk("retire_o", {63'd0, retire_o}, {63'd0, e_retire});
    chk("unit_ready", {61'd0, unit_ready}, {61'd0, e_ready});
    if (adr_known && (e_res_v || !e_retire)) begin
      chk("res_adr", {59'd0, res_adr}, {59'd0, e_adr});
      chk("res_data", {32'd0, res_data}, {32'd0, e_data});
    end
  endtask

  task automatic drive(input int u, input logic v, input logic [4:0] rd, input logic [W-1:0] d);
    unit_v[u] = v;
    unit_rd[u*5 +: 5] = rd;
    unit_data[u*W +: W] = d;
  endtask

  task automatic new_item(input int u, input int prob);
    logic [4:0] rd;
    rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    drive(u, $urandom_range(0, 99) < prob, rd, $urandom);
  endtask

  initial begin
    logic [4:0] order [3];
    int         b_idx;
    int         a_cnt;

    // Reset held two cycles, then five idle cycles.
    rst = 1; tick(); tick();
    rst = 0;
    repeat (5) tick();
    chk("idle_ready", {61'd0, unit_ready}, 64'h7);

    // Single result, two-edge latency, one-cycle pulse.
    drive(0, 1, 5'd5, 32'hDEADBEEF);
    tick();
    unit_v = '0;
    chk("lat_not_yet", {63'd0, res_v}, 64'd0);
    tick();
    chk("lat_res_v", {63'd0, res_v}, 64'd1);
    chk("lat_adr", {59'd0, res_adr}, 64'd5);
    chk("lat_data", {32'd0, res_data}, 64'hDEADBEEF);
    tick();
    chk("lat_pulse", {63'd0, res_v}, 64'd0);

    // Three units push on the same edge.
`ifdef WB_ARB_ROUND_ROBIN_EN
    order[0] = 5'd2; order[1] = 5'd3; order[2] = 5'd1;
`else
    order[0] = 5'd1; order[1] = 5'd2; order[2] = 5'd3;
`endif
    for (int u = 0; u < N; u++) drive(u, 1, 5'(u + 1), 32'h100 + u);
    tick();
    unit_v = '0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("order_adr", {59'd0, res_adr}, {59'd0, order[j]});
    end
    tick();

    // Unit1 burst of three against a continuous unit0 stream.
    b_idx = 0; a_cnt = 0;
    drive(0, 1, 5'd10, 32'hA000);
    drive(1, 1, 5'd20, 32'hB000);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (acc[0]) begin a_cnt++; drive(0, 1, 5'(10 + a_cnt), 32'hA000 + a_cnt); end
      if (acc[1]) begin
        b_idx++;
        if (b_idx < 3) drive(1, 1, 5'(20 + b_idx), 32'hB000 + b_idx);
        else unit_v[1] = 0;
      end
    end
`ifndef WB_ARB_ROUND_ROBIN_EN
    chk("u1_full", {63'd0, unit_ready[1]}, 64'd0);
`endif
    unit_v[0] = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (acc[1]) begin
        b_idx++;
        if (b_idx < 3) drive(1, 1, 5'(20 + b_idx), 32'hB000 + b_idx);
        else unit_v[1] = 0;
      end
    end
    chk("u1_all_accepted", b_idx, 3);

    // x0 result: retired but not written.
    drive(2, 1, 5'd0, 32'h1234);
    tick();
    unit_v = '0;
    tick();
    chk("x0_retire", {63'd0, retire_o}, 64'd1);
    chk("x0_no_write", {63'd0, res_v}, 64'd0);
    tick();

    // Flush with two buffered entries and a same-cycle push.
    drive(0, 1, 5'd7, 32'h77);
    drive(1, 1, 5'd8, 32'h88);
    tick();
    unit_v = '0;
    flush = 1;
    drive(0, 1, 5'd9, 32'h99);
    tick();
    flush = 0; unit_v = '0;
    chk("flush_ready", {61'd0, unit_ready}, 64'h7);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("flush_no_write", {63'd0, res_v}, 64'd0);
    end

    // Randomized traffic with held offers, occasional flush and reset.
    for (int u = 0; u < N; u++) new_item(u, 60);
    for (int c = 0; c < 3000; c++) begin
      flush = ($urandom_range(0, 99) < 3);
      rst   = ($urandom_range(0, 199) == 0);
      tick();
      for (int u = 0; u < N; u++)
        if (!unit_v[u] || acc[u]) new_item(u, (c < 1500) ? 70 : 35);
    end
    rst = 0; flush = 0; unit_v = '0;
    repeat (8) tick();

    chk("x0_never_written", x0_writes, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
